// File: rtl/fb_pkg.sv
// Shared frame-buffer types: geometry, the queued write record and the arbiter FSM states.
package fb_pkg;
  localparam int FB_ADDR_W = 12;
  localparam int FB_DATA_W = 8;
  localparam int FB_WORDS  = 4096;

  typedef struct packed {
    logic [FB_ADDR_W-1:0] addr;
    logic [FB_DATA_W-1:0] data;
  } fb_wr_t;

  typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} fb_state_e;
endpackage

// File: rtl/fb_wr_fifo.sv
// Synchronous FIFO of pending render writes; dout is valid whenever empty is low.
module fb_wr_fifo
  import fb_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   push,
  input  logic   pop,
  input  logic   flush,
  input  fb_wr_t din,
  output logic   full,
  output logic   empty,
  output fb_wr_t dout
);
  localparam int AW = $clog2(DEPTH);

  fb_wr_t        mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rptr];

  // Flush wins over a same-cycle push: everything queued before the clear is dropped.
  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end
endmodule

// File: rtl/fb_write_arbiter.sv
// Shares the single-port frame buffer between scanout (display_on) and queued
// render writes / a full-screen clear that only run during blanking.
module fb_write_arbiter
  import fb_pkg::*;
#(
  parameter int                   DEPTH       = 16,
  parameter logic [FB_DATA_W-1:0] CLEAR_VALUE = 8'h00
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 display_on,
  input  logic [FB_ADDR_W-1:0] vid_addr,
  output logic [FB_DATA_W-1:0] vid_data,
  input  logic                 wr_valid,
  input  logic [FB_ADDR_W-1:0] wr_addr,
  input  logic [FB_DATA_W-1:0] wr_data,
  output logic                 wr_ready,
  input  logic                 clear_req,
  output logic                 clear_busy,
  output logic                 overflow,
  output logic [FB_ADDR_W-1:0] ram_addr,
  output logic                 ram_we,
  output logic [FB_DATA_W-1:0] ram_wdata,
  input  logic [FB_DATA_W-1:0] ram_rdata
);
  localparam int                   STAGES  = 1;
  localparam logic [FB_ADDR_W-1:0] CLR_END = FB_ADDR_W'(FB_WORDS - 1);

  fb_state_e            state, state_nxt;
  logic [FB_ADDR_W-1:0] clr_cnt;
  logic [STAGES:0]      vld_pipe;
  logic                 full, empty, push, pop, flush, clear_step;
  fb_wr_t               din, dout;

  assign clear_busy = (state == CLEAR);
  assign wr_ready   = !full && !clear_busy;
  assign push       = wr_valid && wr_ready;
  assign din        = '{addr: wr_addr, data: wr_data};

  fb_wr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (push),
    .pop  (pop),
    .flush(flush),
    .din  (din),
    .full (full),
    .empty(empty),
    .dout (dout)
  );

  // IDLE issues the first pop itself so a drain starts on the first blanking cycle.
  always_comb begin
    state_nxt  = state;
    pop        = 1'b0;
    flush      = 1'b0;
    clear_step = 1'b0;
    case (state)
      IDLE: begin
        if (clear_req) begin
          state_nxt = CLEAR;
          flush     = 1'b1;
        end else if (!empty && !display_on) begin
          state_nxt = DRAIN;
          pop       = 1'b1;
        end
      end
      DRAIN: begin
        if (clear_req) begin
          state_nxt = CLEAR;
          flush     = 1'b1;
        end else if (empty) begin
          state_nxt = IDLE;
        end else if (!display_on) begin
          pop = 1'b1;
        end
      end
      CLEAR: begin
        if (!display_on) begin
          clear_step = 1'b1;
          if (clr_cnt == CLR_END) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      clr_cnt   <= '0;
      vld_pipe  <= '0;
      vid_data  <= '0;
      overflow  <= 1'b0;
      ram_addr  <= '0;
      ram_we    <= 1'b0;
      ram_wdata <= '0;
    end else begin
      state    <= state_nxt;
      vld_pipe <= {vld_pipe[STAGES-1:0], display_on};
      // vld_pipe[STAGES] lines up with the ram_rdata returned for vid_addr two cycles back.
      vid_data <= vld_pipe[STAGES] ? ram_rdata : '0;
      overflow <= overflow | (wr_valid && !wr_ready);

      if (flush)
        clr_cnt <= '0;
      else if (clear_step && clr_cnt != CLR_END)
        clr_cnt <= clr_cnt + FB_ADDR_W'(1);

      ram_we <= 1'b0;
      if (display_on) begin
        ram_addr <= vid_addr;
      end else if (pop) begin
        ram_we    <= 1'b1;
        ram_addr  <= dout.addr;
        ram_wdata <= dout.data;
      end else if (clear_step) begin
        ram_we    <= 1'b1;
        ram_addr  <= clr_cnt;
        ram_wdata <= CLEAR_VALUE;
      end
    end
  end
endmodule

// File: doc/fb_write_arbiter.md
Name: fb_write_arbiter

Overview:
- Sits directly downstream of the voxel renderer, between its pixel-write stream and the single-port 4096x8 frame buffer RAM.
- Buffers render writes in a small FIFO and drains them only during blanking; video scanout owns the RAM while display_on=1.
- Also provides a blanking-time clear-screen sequencer.
- Scanout read data is returned on vid_data with fixed latency.

Parameters:
- DEPTH, 16, write FIFO entries; power of two, minimum 2.
- CLEAR_VALUE, 8'h00, byte written to every address by a clear.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- display_on  in  1  high during the active video region
- vid_addr  in  12  scanout read address
- vid_data  out  8  scanout read data
- wr_valid  in  1  render write request (driven by the renderer's we)
- wr_addr  in  12  render write address
- wr_data  in  8  render write data
- wr_ready  out  1  write accepted this cycle when wr_valid=1
- clear_req  in  1  single-cycle pulse requesting a full-screen clear
- clear_busy  out  1  clear in progress
- overflow  out  1  sticky: a write was dropped
- ram_addr  out  12  frame buffer address (registered)
- ram_we  out  1  frame buffer write enable (registered)
- ram_wdata  out  8  frame buffer write data (registered)
- ram_rdata  in  8  frame buffer read data, one cycle after ram_addr

Behaviour:
- Reset (reset=0 at a clock edge) forces:
  - ram_addr=0, ram_we=0, ram_wdata=0, vid_data=0
  - clear_busy=0, overflow=0
  - FIFO empty, clear counter=0, FSM=IDLE
  - Reset mid-clear or mid-drain aborts with no further RAM writes.
- wr_ready = !fifo_full && !clear_busy (combinational). Push occurs when wr_valid && wr_ready.
- Overflow:
  - wr_valid && !wr_ready sets overflow; the write is dropped.
  - overflow clears only on reset.
- Port selection, registered and decided from display_on in cycle t:
  - display_on=1: at t+1, ram_we=0 and ram_addr=vid_addr(t); no FIFO pop and no clear step at t.
  - display_on=0: the FSM owns the port.
- Scanout latency: vid_addr(t) -> ram_addr(t+1) -> ram_rdata(t+2) -> vid_data(t+3).
  - vid_data is registered.
  - It loads 0 when the delayed display_on (aligned to t+2) is 0.
- FSM states:
  - IDLE:
    - clear_req=1 -> CLEAR: clear_busy=1 next cycle, counter=0, FIFO flushed (pending entries discarded).
    - Else if FIFO non-empty and display_on=0 -> DRAIN.
  - DRAIN:
    - Each blanking cycle pops one entry; at t+1, ram_we=1, ram_addr/ram_wdata = entry.
    - Writes issue in FIFO order.
    - Returns to IDLE when the FIFO becomes empty.
    - clear_req has priority: -> CLEAR with a flush.
    - display_on=1 pauses DRAIN with no pop; draining resumes at the next blanking cycle.
  - CLEAR:
    - Each blanking cycle writes CLEAR_VALUE to the address held in the counter, then increments it.
    - display_on=1 pauses the clear; the counter holds.
    - After address 4095 is written: IDLE, clear_busy=0 on the following cycle.
    - clear_req during CLEAR is ignored (no restart).
- Simultaneous push and pop: allowed when the FIFO is non-empty; occupancy is unchanged.
- A push during CLEAR cannot occur because wr_ready=0.
- The FIFO counter never wraps past DEPTH. Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- The clear counter is 12 bits; 4095 is the terminal value. It does not wrap into a second pass.

Decomposition:
- fb_pkg holds:
  - FB_ADDR_W=12, FB_DATA_W=8, FB_WORDS=4096
  - typedef fb_wr_t packed {addr[11:0], data[7:0]}
  - FSM state enum: IDLE, DRAIN, CLEAR
- Sub-module fb_wr_fifo (synchronous FIFO of fb_wr_t, parameter DEPTH):
  - ports: push, pop, flush, full, empty, dout
  - dout is valid combinationally while not empty

Test Plan:
- Reset check: hold reset=0 for 3 cycles while wr_valid=1 -> all outputs 0, wr_ready=1 after release, overflow=0.
- Blanking drain: display_on=0; push (0x010,0xFF), (0x020,0x0F) -> ram_we=1 with those pairs on two consecutive cycles, in that order, starting one cycle after each pop; FIFO then empty, FSM=IDLE.
- Scanout priority: display_on=1; push 5 writes; vid_addr=0x123 with RAM model 0x123=0xAB -> ram_we stays 0; vid_data=0xAB three cycles after vid_addr; the 5 writes drain on the first 5 blanking cycles.
- Overflow: display_on=1; push 17 consecutive writes with DEPTH=16 -> wr_ready low on the 17th, overflow=1 and stays 1; only 16 writes reach RAM in blanking.
- Clear: 3 entries queued, pulse clear_req during blanking -> entries discarded; 4096 writes of 0x00 to addresses 0..4095 in order; a display_on=1 window of 100 cycles mid-clear pauses the count; clear_busy drops after address 4095; wr_valid during the clear sets overflow.
- Reset mid-clear: assert reset=0 at counter 0x800 -> ram_we=0 the next cycle, clear_busy=0, no further writes.
